// File: rtl/board_tile_renderer.sv
`default_nettype none
// board_tile_renderer: per-square state table with blanking-deferred update FIFO,
// tile lookup stage and ROM-latency-aligned RGB332 output with selection cursor.
module board_tile_renderer #(
  parameter int NUM_BOARDS  = 2,
  parameter int GRID_N      = 10,
  parameter int SQ_LOG2     = 4,
  parameter int BORDER      = 6,
  parameter int ORIGIN_X    = 234,
  parameter int ORIGIN_Y    = 67,
  parameter int BOARD_PITCH = 173,
  parameter int FIFO_DEPTH  = 8,
  parameter int ROM_LAT     = 1,
  parameter int BLINK_EN    = 1,
  parameter int BLINK_LOG2  = 5,
  parameter int V_ACTIVE    = 480,
  localparam int BW = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1,
  localparam int SW = $clog2(GRID_N*GRID_N),
  localparam int PW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               vga_clk,
  input  logic               rst_n,
  input  logic [9:0]         next_x,
  input  logic [9:0]         next_y,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [BW-1:0]      upd_board,
  input  logic [SW-1:0]      upd_square,
  input  logic [8:0]         upd_data,
  output logic               tile_valid,
  output logic [BW-1:0]      tile_board,
  output logic [SQ_LOG2-1:0] tile_off_x,
  output logic [SQ_LOG2-1:0] tile_off_y,
  output logic [8:0]         tile_data,
  input  logic [7:0]         sprite_pixel,
  output logic [7:0]         rgb,
  output logic               in_frame,
  output logic [PW-1:0]      pending
);

  localparam int NSQ     = GRID_N * GRID_N;
  localparam int NENT    = NUM_BOARDS * NSQ;
  localparam int TW      = $clog2(NENT);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int EW      = BW + SW + 9;
  localparam int SQ_SPAN = GRID_N << SQ_LOG2;
  localparam int FW      = BLINK_LOG2 + 1;

  logic [8:0]    table_q [NENT];
  logic [EW-1:0] fifo_q  [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW-1:0] count_q;
  logic          blank, push, pop;
  logic [EW-1:0] head;
  logic [TW-1:0] wr_idx;

  assign blank     = next_y >= 10'(V_ACTIVE);
  assign upd_ready = count_q != PW'(FIFO_DEPTH);
  assign push      = upd_valid && upd_ready;
  assign pop       = blank && (count_q != '0);
  assign pending   = count_q;
  assign head      = fifo_q[rd_ptr_q];
  assign wr_idx    = TW'(int'(head[EW-1 -: BW]) * NSQ + int'(head[9 +: SW]));

  always_ff @(posedge vga_clk) begin
    if (push) fifo_q[wr_ptr_q] <= {upd_board, upd_square, upd_data};
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + PW'(push) - PW'(pop);
    end
  end

  // Table is only written from the FIFO head during blanking, so a frame never tears.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NENT; i++) table_q[i] <= '0;
    end else if (pop) begin
      table_q[wr_idx] <= head[8:0];
    end
  end

  int                 px, py, lx, ly;
  logic               hit_d, frame_d;
  logic [BW-1:0]      board_d;
  logic [SQ_LOG2-1:0] offx_d, offy_d;
  logic [TW-1:0]      rd_idx_d;

  // Walk boards from highest to lowest so the lowest-numbered hit wins.
  always_comb begin
    hit_d    = 1'b0;
    frame_d  = 1'b0;
    board_d  = '0;
    offx_d   = '0;
    offy_d   = '0;
    rd_idx_d = '0;
    px       = int'(next_x);
    py       = int'(next_y);
    lx       = px - (ORIGIN_X + BORDER);
    ly       = 0;
    for (int b = NUM_BOARDS - 1; b >= 0; b--) begin
      ly = py - (ORIGIN_Y + b * BOARD_PITCH + BORDER);
      if (px >= ORIGIN_X && px < ORIGIN_X + BOARD_PITCH &&
          py >= ORIGIN_Y + b * BOARD_PITCH && py < ORIGIN_Y + (b + 1) * BOARD_PITCH)
        frame_d = 1'b1;
      if (lx >= 0 && lx < SQ_SPAN && ly >= 0 && ly < SQ_SPAN) begin
        hit_d    = 1'b1;
        board_d  = BW'(b);
        offx_d   = lx[SQ_LOG2-1:0];
        offy_d   = ly[SQ_LOG2-1:0];
        rd_idx_d = TW'(b * NSQ + (ly >> SQ_LOG2) * GRID_N + (lx >> SQ_LOG2));
      end
    end
  end

  logic [8:0]     rd_data;
  logic [FW-1:0]  frame_cnt_q;
  logic           blink_on, inv_d;
  logic [ROM_LAT:0] frame_pipe_q, inv_pipe_q;

  assign rd_data  = table_q[rd_idx_d];
  assign blink_on = (BLINK_EN == 0) || frame_cnt_q[BLINK_LOG2];
  assign inv_d    = hit_d && rd_data[0] && (offx_d != '0) && (offy_d != '0) && blink_on;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_valid   <= 1'b0;
      tile_board   <= '0;
      tile_off_x   <= '0;
      tile_off_y   <= '0;
      tile_data    <= '0;
      frame_pipe_q <= '0;
      inv_pipe_q   <= '0;
      frame_cnt_q  <= '0;
      rgb          <= 8'hFF;
      in_frame     <= 1'b0;
    end else begin
      tile_valid   <= hit_d;
      tile_board   <= board_d;
      tile_off_x   <= offx_d;
      tile_off_y   <= offy_d;
      tile_data    <= hit_d ? rd_data : 9'd0;
      // Bit 0 is the stage-1 copy; bit ROM_LAT lines up with sprite_pixel.
      frame_pipe_q <= {frame_pipe_q[ROM_LAT-1:0], frame_d};
      inv_pipe_q   <= {inv_pipe_q[ROM_LAT-1:0], inv_d};
      if (next_y == 10'(V_ACTIVE) && next_x == 10'd0)
        frame_cnt_q <= frame_cnt_q + FW'(1);
      in_frame     <= frame_pipe_q[ROM_LAT];
      rgb          <= frame_pipe_q[ROM_LAT] ?
                      (inv_pipe_q[ROM_LAT] ? ~sprite_pixel : sprite_pixel) : 8'hFF;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_board_tile_renderer.sv
`default_nettype none
// Randomized bench for board_tile_renderer: a geometric pixel/table/FIFO model
// predicts every output cycle by cycle, plus hand-computed directed checks.
module tb_board_tile_renderer;
  localparam int RL    = 3;
  localparam int NB    = 2;
  localparam int GN    = 10;
  localparam int NSQ   = 100;
  localparam int FX0   = 234;
  localparam int FY0   = 67;
  localparam int PITCH = 173;
  localparam int SQX0  = 240;
  localparam int SQY0  = 73;
  localparam int DEPTH = 8;
  localparam int HIST  = 32768;

  logic       vga_clk = 1'b0;
  logic       rst_n;
  logic [9:0] next_x, next_y;
  logic       upd_valid, upd_ready;
  logic [0:0] upd_board;
  logic [6:0] upd_square;
  logic [8:0] upd_data;
  logic       tile_valid;
  logic [0:0] tile_board;
  logic [3:0] tile_off_x, tile_off_y;
  logic [8:0] tile_data;
  logic [7:0] sprite_pixel, rgb;
  logic       in_frame;
  logic [3:0] pending;

  board_tile_renderer #(.ROM_LAT(RL), .BLINK_LOG2(1)) dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .next_x(next_x), .next_y(next_y),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_board(upd_board),
    .upd_square(upd_square), .upd_data(upd_data), .tile_valid(tile_valid),
    .tile_board(tile_board), .tile_off_x(tile_off_x), .tile_off_y(tile_off_y),
    .tile_data(tile_data), .sprite_pixel(sprite_pixel), .rgb(rgb),
    .in_frame(in_frame), .pending(pending)
  );

  always #20 vga_clk = ~vga_clk;

  typedef struct packed { logic [0:0] b; logic [6:0] s; logic [8:0] d; } upd_t;

  logic [8:0] tbl [NB][NSQ];
  upd_t       fq [$];
  int         fc = 0;
  int         cur = -1;
  int         last_rst = -1;
  int         n_cmp = 0, n_err = 0;
  bit         cmp_en = 0;

  bit         h_tv [HIST];
  int         h_tb [HIST], h_ox [HIST], h_oy [HIST], h_q [HIST];
  logic [8:0] h_td [HIST];
  bit         h_if [HIST], h_inv [HIST];
  logic [7:0] h_sp [HIST];

  bit         s_rst, s_v, sp_fix_en;
  int         s_x, s_y, s_b, s_s, s_d;
  logic [7:0] sp_fix;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cur);
    end
  endtask

  function automatic void model(int k);
    int lx, ly;
    bit hit;
    upd_t e;
    hit = 0;
    h_sp[k] = sprite_pixel;
    h_tv[k] = 0; h_tb[k] = 0; h_ox[k] = 0; h_oy[k] = 0;
    h_td[k] = '0; h_if[k] = 0; h_inv[k] = 0;
    if (!s_rst) begin
      for (int b = 0; b < NB; b++)
        for (int s = 0; s < NSQ; s++) tbl[b][s] = '0;
      fq.delete();
      fc = 0;
      last_rst = k;
      h_q[k] = 0;
      return;
    end
    h_q[k] = fq.size();
    for (int b = 0; b < NB; b++)
      if (s_x >= FX0 && s_x < FX0 + PITCH && s_y >= FY0 + b*PITCH && s_y < FY0 + (b+1)*PITCH)
        h_if[k] = 1;
    for (int b = 0; b < NB; b++) begin
      lx = s_x - SQX0;
      ly = s_y - (SQY0 + b*PITCH);
      if (!hit && lx >= 0 && lx < 160 && ly >= 0 && ly < 160) begin
        hit = 1;
        h_tv[k] = 1; h_tb[k] = b; h_ox[k] = lx % 16; h_oy[k] = ly % 16;
        h_td[k] = tbl[b][(ly/16)*GN + lx/16];
      end
    end
    h_inv[k] = h_tv[k] && h_td[k][0] && h_ox[k] != 0 && h_oy[k] != 0 && ((fc/2) % 2 == 1);
    if (s_y == 480 && s_x == 0) fc = (fc + 1) % 4;
    if (s_y >= 480 && fq.size() > 0) begin
      e = fq.pop_front();
      tbl[e.b][e.s] = e.d;
    end
    if (s_v && h_q[k] < DEPTH) begin
      e.b = 1'(s_b); e.s = 7'(s_s); e.d = 9'(s_d);
      fq.push_back(e);
    end
  endfunction

  task automatic step();
    @(posedge vga_clk);
    #1;
    cur = cur + 1;
    rst_n        = s_rst;
    next_x       = 10'(s_x);
    next_y       = 10'(s_y);
    upd_valid    = s_v;
    upd_board    = 1'(s_b);
    upd_square   = 7'(s_s);
    upd_data     = 9'(s_d);
    sprite_pixel = sp_fix_en ? sp_fix : 8'($urandom);
    model(cur);
  endtask

  task automatic px(input int x, input int y);
    s_x = x; s_y = y; s_v = 0;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px(0, 0);
  endtask

  task automatic commit(input int n);
    for (int i = 0; i < n; i++) px(5, 490);
  endtask

  task automatic push_at(input int x, input int y, input int b, input int s, input int d);
    s_x = x; s_y = y; s_v = 1; s_b = b; s_s = s; s_d = d;
    step();
    s_v = 0;
  endtask

  task automatic rnd_upd();
    s_v = ($urandom_range(0, 3) == 0);
    s_b = $urandom_range(0, 1);
    s_s = $urandom_range(0, 99);
    s_d = $urandom_range(0, 511);
  endtask

  int         cm, c1, c2;
  bit         e_if;
  logic [7:0] e_rgb;

  initial begin
    forever begin
      @(negedge vga_clk);
      if (cmp_en) begin
        cm = cur;
        chk("pending", 32'(pending), 32'(h_q[cm]));
        chk("upd_ready", 32'(upd_ready), 32'(h_q[cm] < DEPTH));
        c1 = cm - 1;
        if (c1 <= last_rst) begin
          chk("tile_valid", 32'(tile_valid), 0);
          chk("tile_data", 32'(tile_data), 0);
        end else begin
          chk("tile_valid", 32'(tile_valid), 32'(h_tv[c1]));
          chk("tile_data", 32'(tile_data), 32'(h_td[c1]));
          if (h_tv[c1]) begin
            chk("tile_board", 32'(tile_board), 32'(h_tb[c1]));
            chk("tile_off_x", 32'(tile_off_x), 32'(h_ox[c1]));
            chk("tile_off_y", 32'(tile_off_y), 32'(h_oy[c1]));
          end
        end
        c2 = cm - RL - 2;
        if (c2 <= last_rst) begin
          e_if = 0; e_rgb = 8'hFF;
        end else begin
          e_if  = h_if[c2];
          e_rgb = !e_if ? 8'hFF : (h_inv[c2] ? ~h_sp[cm-1] : h_sp[cm-1]);
        end
        chk("in_frame", 32'(in_frame), 32'(e_if));
        chk("rgb", 32'(rgb), 32'(e_rgb));
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int nb;

  initial begin
    rst_n = 1'b0; next_x = '0; next_y = '0; upd_valid = 1'b0;
    upd_board = '0; upd_square = '0; upd_data = '0; sprite_pixel = '0;
    s_rst = 0; s_v = 0; s_x = 0; s_y = 0; s_b = 0; s_s = 0; s_d = 0;
    sp_fix_en = 0; sp_fix = 8'h3C;
    idle(3);
    s_rst = 1;
    idle(1);
    cmp_en = 1;
    @(negedge vga_clk);
    chk("reset upd_ready", 32'(upd_ready), 1);
    chk("reset pending", 32'(pending), 0);
    chk("reset rgb", 32'(rgb), 32'h0FF);
    chk("reset in_frame", 32'(in_frame), 0);
    chk("reset tile_valid", 32'(tile_valid), 0);

    // Deferred commit: board 1, square 37 (row 3, col 7)
    push_at(300, 100, 1, 37, 9'h180);
    px(357, 299); idle(1);
    @(negedge vga_clk);
    chk("deferred board", 32'(tile_board), 1);
    chk("deferred before blank", 32'(tile_data), 0);
    commit(1);
    px(357, 299); idle(1);
    @(negedge vga_clk);
    chk("deferred after blank", 32'(tile_data), 32'h180);
    chk("deferred off_x", 32'(tile_off_x), 5);

    // Mapping corner: board 0, square 99
    push_at(0, 100, 0, 99, 9'h0AA);
    commit(1);
    px(399, 232); idle(1);
    @(negedge vga_clk);
    chk("corner valid", 32'(tile_valid), 1);
    chk("corner off", 32'({tile_off_x, tile_off_y}), 32'h0FF);
    chk("corner data", 32'(tile_data), 32'h0AA);
    px(400, 232); idle(1);
    @(negedge vga_clk);
    chk("right of grid valid", 32'(tile_valid), 0);

    // FIFO full, overflow ignored, in-order drain
    for (int i = 0; i < 8; i++) push_at(0, 100, 0, (i == 7) ? 10 : 10 + i, 9'h100 + i);
    s_x = 0; s_y = 100; s_v = 1; s_b = 0; s_s = 20; s_d = 9'h1FF;
    step();
    s_v = 0;
    @(negedge vga_clk);
    chk("full pending", 32'(pending), 8);
    chk("full upd_ready", 32'(upd_ready), 0);
    idle(1);
    @(negedge vga_clk);
    chk("overflow ignored", 32'(pending), 8);
    commit(4); idle(1);
    @(negedge vga_clk);
    chk("half drained", 32'(pending), 4);
    commit(4); idle(1);
    @(negedge vga_clk);
    chk("drained", 32'(pending), 0);
    px(245, 94); idle(1);
    @(negedge vga_clk);
    chk("duplicate last wins", 32'(tile_data), 32'h107);
    px(261, 94); idle(1);
    @(negedge vga_clk);
    chk("square 11", 32'(tile_data), 32'h101);
    px(245, 110); idle(1);
    @(negedge vga_clk);
    chk("dropped square 20", 32'(tile_data), 0);

    // Cursor blink with half-period of 2 frames
    push_at(0, 100, 0, 0, 9'h001);
    commit(1);
    sp_fix_en = 1;
    for (int f = 0; f < 6; f++) begin
      px(245, 78); px(240, 78); idle(4);
      @(negedge vga_clk);
      chk("cursor interior", 32'(rgb), (f == 2 || f == 3) ? 32'h0C3 : 32'h03C);
      idle(1);
      @(negedge vga_clk);
      chk("cursor gridline", 32'(rgb), 32'h03C);
      px(0, 480);
    end
    sp_fix_en = 0;

    // Random frames with a mid-frame reset
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          s_x = $urandom_range(0, 639); s_y = $urandom_range(0, 479);
        end else begin
          s_x = $urandom_range(225, 420); s_y = $urandom_range(55, 430);
        end
        rnd_upd();
        s_rst = !(f == 15 && (i == 70 || i == 71));
        step();
      end
      s_rst = 1;
      s_x = 0; s_y = 480; rnd_upd(); step();
      nb = $urandom_range(0, 12);
      for (int i = 0; i < nb; i++) begin
        s_x = $urandom_range(1, 799); s_y = $urandom_range(481, 524);
        rnd_upd(); step();
      end
    end
    s_v = 0;
    idle(8);
    @(negedge vga_clk);
    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
